// File: rtl/buffer_spi_reader_pkg.sv
// Shared buffer geometry and read-side FSM states.
// The write path imports the same package for ADDR_W/DEPTH.
package mem_buf_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } rd_state_t;

    // Pointer increment; wraps DEPTH-1 -> 0 through natural overflow.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] ptr);
        return ptr + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/buffer_spi_reader_if.sv
// Bus bundle for the buffer read side: control, RAM read port and SPI master pins.
interface buffer_spi_reader_if import mem_buf_pkg::*; ();

    logic              enable;
    logic [ADDR_W-1:0] wr_index;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] address;
    logic              read_pulse;
    logic              spi_sclk;
    logic              spi_mosi;
    logic              spi_cs_n;
    logic              busy;
    logic              word_done;

    modport master (
        input  enable, wr_index, rd_data,
        output address, read_pulse, spi_sclk, spi_mosi, spi_cs_n, busy, word_done
    );

    modport slave (
        output enable, wr_index, rd_data,
        input  address, read_pulse, spi_sclk, spi_mosi, spi_cs_n, busy, word_done
    );

endinterface

// File: rtl/spi_tx_shifter.sv
// SPI mode-0 frame transmitter: CLK_DIV setup, DATA_W clock pulses, CLK_DIV hold,
// then a one-cycle done pulse as cs_n returns high.
module spi_tx_shifter import mem_buf_pkg::*; #(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              done
);

    localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int TICK_W = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(2 * DATA_W);

    logic              active_q, active_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              done_q, done_d;
    logic              tick_s;

    // Even half-period ticks raise sclk, odd ones lower it and advance the data;
    // the tick after the last fall closes the frame.
    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        tick_d   = tick_q;
        shreg_d  = shreg_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        cs_n_d   = cs_n_q;
        done_d   = 1'b0;
        tick_s   = active_q && (div_q == DIV_LAST);
        if (load) begin
            active_d = 1'b1;
            div_d    = '0;
            tick_d   = '0;
            shreg_d  = data;
            mosi_d   = data[DATA_W-1];
            sclk_d   = 1'b0;
            cs_n_d   = 1'b0;
        end else if (tick_s) begin
            div_d  = '0;
            tick_d = tick_q + TICK_W'(1);
            if (tick_q == TICK_LAST) begin
                active_d = 1'b0;
                tick_d   = '0;
                sclk_d   = 1'b0;
                mosi_d   = 1'b0;
                cs_n_d   = 1'b1;
                done_d   = 1'b1;
            end else if (!tick_q[0]) begin
                sclk_d = 1'b1;
            end else begin
                sclk_d  = 1'b0;
                shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                mosi_d  = shreg_q[DATA_W-2];
            end
        end else if (active_q) begin
            div_d = div_q + DIV_W'(1);
        end else begin
            div_d = '0;
        end
    end

    // Shifter state register with synchronous active-low reset (aborts any frame).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            div_q    <= '0;
            tick_q   <= '0;
            shreg_q  <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            tick_q   <= tick_d;
            shreg_q  <= shreg_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            cs_n_q   <= cs_n_d;
            done_q   <= done_d;
        end
    end

    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign cs_n = cs_n_q;
    assign done = done_q;

endmodule

// File: rtl/buffer_spi_reader.sv
// Buffer read side: fetches one word per frame from the shared RAM and streams it
// MSB-first over SPI until the read pointer reaches the writer's next-write index.
module buffer_spi_reader import mem_buf_pkg::*; #(
    parameter int RAM_LAT = 2,
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    buffer_spi_reader_if.master bus
);

    localparam logic [7:0] FETCH_LAST = 8'(RAM_LAT);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              read_pulse_q, read_pulse_d;
    logic              busy_q, busy_d;
    logic              avail_s;
    logic              load_s;
    logic              tx_done_s;

    // A lapped writer looks exactly like an empty buffer.
    assign avail_s = (bus.wr_index != rd_ptr_q);

    // Next-state logic; wr_index is only consulted in IDLE and at the GAP exit.
    always_comb begin
        state_d = state_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d = cnt_q;
        load_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable && avail_s) begin
                    state_d = FETCH;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (cnt_q == FETCH_LAST) begin
                    load_s   = 1'b1;
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                    cnt_d    = 8'd0;
                    state_d  = SHIFT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SHIFT: begin
                if (tx_done_s) begin
                    cnt_d   = 8'd0;
                    state_d = GAP;
                end else begin
                    state_d = SHIFT;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = (bus.enable && avail_s) ? FETCH : IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        read_pulse_d = (state_d == FETCH);
        busy_d       = (state_d != IDLE);
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rd_ptr_q     <= '0;
            cnt_q        <= 8'd0;
            read_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            read_pulse_q <= read_pulse_d;
            busy_q       <= busy_d;
        end
    end

    spi_tx_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_s),
        .data  (bus.rd_data),
        .sclk  (bus.spi_sclk),
        .mosi  (bus.spi_mosi),
        .cs_n  (bus.spi_cs_n),
        .done  (tx_done_s)
    );

    assign bus.address    = rd_ptr_q;
    assign bus.read_pulse = read_pulse_q;
    assign bus.busy       = busy_q;
    assign bus.word_done  = tx_done_s;

endmodule

// File: tb/tb_buffer_spi_reader.sv
// Scoreboard bench for buffer_spi_reader: RAM model with 2-cycle registered read,
// SPI slave model sampling on sclk rise, one task per scenario.
module tb_buffer_spi_reader;
    import mem_buf_pkg::*;

    localparam int RAM_LAT   = 2;
    localparam int CLK_DIV   = 4;
    localparam int GAP_CYC   = 4;
    localparam int FRAME_LEN = 2 * DATA_W * CLK_DIV + CLK_DIV;
    // cs_n-high cycles between frames: done cycle, GAP state, then the next FETCH.
    localparam int GAP_LEN   = 1 + GAP_CYC + RAM_LAT + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    buffer_spi_reader_if bus ();

    buffer_spi_reader #(.RAM_LAT(RAM_LAT), .CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] ram_s1;
    always @(posedge clk) begin
        ram_s1      <= mem[bus.address];
        bus.rd_data <= ram_s1;
    end

    int cyc = 0;
    int wd_cnt = 0;
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.word_done === 1'b1) wd_cnt = wd_cnt + 1;
    end

    logic prev_sclk = 1'b0;
    logic prev_cs = 1'b1;
    logic [DATA_W-1:0] sh = '0;
    int nb = 0, rises = 0, aborted = 0, fall_cyc = 0, rise_cyc = 0;
    logic [DATA_W-1:0] rx_q [$];
    int gap_q [$];
    int len_q [$];
    int bits_q [$];
    always @(bus.spi_sclk or bus.spi_cs_n) begin
        if (bus.spi_sclk === 1'b1 && prev_sclk === 1'b0 && bus.spi_cs_n === 1'b0) begin
            sh = {sh[DATA_W-2:0], bus.spi_mosi};
            nb = nb + 1;
            rises = rises + 1;
        end
        if (bus.spi_cs_n === 1'b0 && prev_cs === 1'b1) begin
            nb = 0;
            fall_cyc = cyc;
            gap_q.push_back(cyc - rise_cyc);
        end
        if (bus.spi_cs_n === 1'b1 && prev_cs === 1'b0) begin
            rise_cyc = cyc;
            len_q.push_back(cyc - fall_cyc);
            bits_q.push_back(nb);
            if (nb == DATA_W) rx_q.push_back(sh);
            else aborted = aborted + 1;
        end
        prev_sclk = bus.spi_sclk;
        prev_cs = bus.spi_cs_n;
    end

    logic [DATA_W-1:0] exp_q [$];
    int rx_rd = 0;

    task automatic do_reset();
        rst_n = 1'b0;
        bus.enable = 1'b0;
        bus.wr_index = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_rx(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_q.size() >= target && bus.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rises(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rises >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_words(input int n, input string name);
        logic [DATA_W-1:0] e;
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() <= rx_rd || rx_q[rx_rd] !== e) begin
                failures++;
                $display("FAIL %s word %0d: got %h expected %h", name, k,
                         (rx_q.size() > rx_rd) ? rx_q[rx_rd] : 16'hxxxx, e);
            end
            rx_rd++;
        end
    endtask

    task automatic test_reset();
        bit cs_low;
        rst_n = 1'b0;
        bus.enable = 1'b1;
        bus.wr_index = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.address !== 15'd0) begin failures++; $display("FAIL reset_address: got %h expected 0", bus.address); end
        checks++; if (bus.read_pulse !== 1'b0) begin failures++; $display("FAIL reset_read_pulse: got %b expected 0", bus.read_pulse); end
        checks++; if (bus.spi_sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk: got %b expected 0", bus.spi_sclk); end
        checks++; if (bus.spi_mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi: got %b expected 0", bus.spi_mosi); end
        checks++; if (bus.spi_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n: got %b expected 1", bus.spi_cs_n); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.word_done !== 1'b0) begin failures++; $display("FAIL reset_word_done: got %b expected 0", bus.word_done); end
        rst_n = 1'b1;
        cs_low = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.spi_cs_n !== 1'b1 || bus.busy !== 1'b0) cs_low = 1'b1;
        end
        checks++; if (cs_low) begin failures++; $display("FAIL idle_empty: got activity expected idle"); end
    endtask

    task automatic test_single();
        int base_rises, base_wd, lat;
        bit ok;
        mem[0] = 16'hA5C3;
        exp_q.push_back(16'hA5C3);
        base_rises = rises;
        base_wd = wd_cnt;
        bus.enable = 1'b1;
        bus.wr_index = 15'd1;
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (bus.spi_cs_n === 1'b0) break;
        end
        checks++; if (lat != RAM_LAT + 2) begin failures++; $display("FAIL single_latency: got %0d expected %0d", lat, RAM_LAT + 2); end
        wait_rx(rx_rd + 1, 500, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_timeout: got no frame expected one"); end
        check_words(1, "single");
        checks++; if (rises - base_rises != DATA_W) begin failures++; $display("FAIL single_rises: got %0d expected %0d", rises - base_rises, DATA_W); end
        checks++; if (wd_cnt - base_wd != 1) begin failures++; $display("FAIL single_word_done: got %0d expected 1", wd_cnt - base_wd); end
        checks++; if (bus.address !== 15'd1) begin failures++; $display("FAIL single_rd_ptr: got %h expected 1", bus.address); end
        checks++; if (bus.spi_cs_n !== 1'b1) begin failures++; $display("FAIL single_idle_cs: got %b expected 1", bus.spi_cs_n); end
    endtask

    task automatic test_burst();
        logic [DATA_W-1:0] words [4];
        int base_gap, base_len;
        bit ok;
        words = '{16'h0001, 16'h8000, 16'hFFFF, 16'h1234};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            mem[k] = words[k];
            exp_q.push_back(words[k]);
        end
        base_gap = gap_q.size();
        base_len = len_q.size();
        bus.enable = 1'b1;
        bus.wr_index = 15'd4;
        wait_rx(rx_rd + 4, 2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL burst_timeout: got %0d frames expected 4", rx_q.size() - rx_rd); end
        check_words(4, "burst");
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (gap_q.size() <= base_gap + k || gap_q[base_gap + k] != GAP_LEN) begin
                failures++;
                $display("FAIL burst_gap %0d: got %0d expected %0d", k,
                         (gap_q.size() > base_gap + k) ? gap_q[base_gap + k] : -1, GAP_LEN);
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (len_q.size() <= base_len + k || len_q[base_len + k] != FRAME_LEN) begin
                failures++;
                $display("FAIL burst_frame_len %0d: got %0d expected %0d", k,
                         (len_q.size() > base_len + k) ? len_q[base_len + k] : -1, FRAME_LEN);
            end
        end
        checks++; if (bus.address !== 15'd4) begin failures++; $display("FAIL burst_rd_ptr: got %h expected 4", bus.address); end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        mem[DEPTH-1] = 16'hBEEF;
        mem[0] = 16'hCAFE;
        @(negedge clk);
        force dut.rd_ptr_d = 15'h7FFF;
        @(negedge clk);
        release dut.rd_ptr_d;
        @(negedge clk);
        checks++; if (bus.address !== 15'h7FFF) begin failures++; $display("FAIL wrap_preload: got %h expected 7fff", bus.address); end
        exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'hCAFE);
        bus.wr_index = 15'd1;
        bus.enable = 1'b1;
        wait_rx(rx_rd + 2, 1000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout: got %0d frames expected 2", rx_q.size() - rx_rd); end
        check_words(2, "wrap");
        checks++; if (bus.address !== 15'd1) begin failures++; $display("FAIL wrap_rd_ptr: got %h expected 1", bus.address); end
    endtask

    task automatic test_enable_drop();
        bit ok, active;
        int base_rx;
        mem[1] = 16'h1111;
        mem[2] = 16'h2222;
        mem[3] = 16'h3333;
        exp_q.push_back(16'h1111);
        base_rx = rx_q.size();
        bus.enable = 1'b1;
        bus.wr_index = 15'd4;
        wait_rises(rises + 5, 500, ok);
        checks++; if (!ok) begin failures++; $display("FAIL drop_start: got no sclk expected 5 rises"); end
        bus.enable = 1'b0;
        wait_rx(base_rx + 1, 1000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL drop_timeout: got no frame end expected one"); end
        check_words(1, "drop");
        checks++; if (bits_q.size() == 0 || bits_q[bits_q.size() - 1] != DATA_W) begin failures++; $display("FAIL drop_bits: got partial expected %0d bits", DATA_W); end
        active = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.read_pulse !== 1'b0 || bus.spi_cs_n !== 1'b1 || bus.busy !== 1'b0) active = 1'b1;
        end
        checks++; if (active) begin failures++; $display("FAIL drop_no_fetch: got activity expected idle"); end
        checks++; if (rx_q.size() != base_rx + 1) begin failures++; $display("FAIL drop_frames: got %0d expected 1", rx_q.size() - base_rx); end
        checks++; if (bus.address !== 15'd2) begin failures++; $display("FAIL drop_rd_ptr: got %h expected 2", bus.address); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int base_ab, base_rx;
        base_ab = aborted;
        base_rx = rx_q.size();
        bus.enable = 1'b1;
        wait_rises(rises + 8, 500, ok);
        checks++; if (!ok) begin failures++; $display("FAIL midrst_start: got no sclk expected 8 rises"); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.spi_cs_n !== 1'b1) begin failures++; $display("FAIL midrst_cs_n: got %b expected 1", bus.spi_cs_n); end
        checks++; if (bus.spi_sclk !== 1'b0) begin failures++; $display("FAIL midrst_sclk: got %b expected 0", bus.spi_sclk); end
        checks++; if (bus.address !== 15'd0) begin failures++; $display("FAIL midrst_rd_ptr: got %h expected 0", bus.address); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        checks++; if (aborted != base_ab + 1) begin failures++; $display("FAIL midrst_aborted: got %0d expected 1", aborted - base_ab); end
        checks++; if (bits_q.size() == 0 || bits_q[bits_q.size() - 1] != 8) begin failures++; $display("FAIL midrst_bits: got %0d expected 8", (bits_q.size() > 0) ? bits_q[bits_q.size() - 1] : -1); end
        checks++; if (rx_q.size() != base_rx) begin failures++; $display("FAIL midrst_rx: got %0d words expected 0", rx_q.size() - base_rx); end
        bus.enable = 1'b0;
        bus.wr_index = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.enable = 1'b0;
        bus.wr_index = '0;
        test_reset();
        test_single();
        test_burst();
        test_wrap();
        test_enable_drop();
        test_reset_midframe();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
